// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - shared op codes, FSM states and sizing helper for the sliced logic unit
package logic_unit_pkg;

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_NOR   = 3'b010,
    OP_XOR   = 3'b011,
    OP_NAND  = 3'b100,
    OP_XNOR  = 3'b101,
    OP_ANDN  = 3'b110,
    OP_PASSA = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A single-slice datapath still needs a 1-bit counter to keep the port legal.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sliced_logic_unit_if.sv
// rtl/sliced_logic_unit_if.sv - request/result bundle between a requester and the sliced logic unit
interface sliced_logic_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (output start, op, a, b, input busy, done, result, zero);
  modport slave  (input start, op, a, b, output busy, done, result, zero);
endinterface

// File: rtl/logic_slice.sv
// rtl/logic_slice.sv - combinational bitwise operator applied to one slice of the operands
module logic_slice
  import logic_unit_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic [2:0]       op,
  output logic [SLICE-1:0] y
);

  always_comb begin
    y = '0;
    case (op_e'(op))
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_NOR:   y = ~(a | b);
      OP_XOR:   y = a ^ b;
      OP_NAND:  y = ~(a & b);
      OP_XNOR:  y = ~(a ^ b);
      OP_ANDN:  y = a & ~b;
      OP_PASSA: y = a;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/sliced_logic_unit.sv
// rtl/sliced_logic_unit.sv - multi-cycle bitwise unit processing SLICE bits per cycle, LSB slice first
module sliced_logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sliced_logic_unit_if.slave   bus
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_nx;
  logic             zero_q;
  logic [SLICE-1:0] a_sl, b_sl, y_sl;
  logic             accept;

  assign accept = (state == ST_IDLE) && bus.start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (bus.start) state_nx = ST_RUN;
      ST_RUN:  if (cnt == LAST) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Constant-index compare chain keeps the slice mux and merge free of variable part-selects.
  always_comb begin
    a_sl   = '0;
    b_sl   = '0;
    res_nx = res_q;
    for (int k = 0; k < N; k++) begin
      if (cnt == CW'(k)) begin
        a_sl = a_q[k*SLICE +: SLICE];
        b_sl = b_q[k*SLICE +: SLICE];
        res_nx[k*SLICE +: SLICE] = y_sl;
      end
    end
  end

  logic_slice #(.SLICE(SLICE)) u_slice (
    .a  (a_sl),
    .b  (b_sl),
    .op (op_q),
    .y  (y_sl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      op_q   <= bus.op;
      a_q    <= bus.a;
      b_q    <= bus.b;
      res_q  <= '0;
      zero_q <= 1'b0;
    end else if (state == ST_RUN) begin
      res_q <= res_nx;
      // Counter parks on the last slice so it never indexes past the operands.
      if (cnt == LAST) zero_q <= (res_nx == '0);
      else             cnt    <= cnt + 1'b1;
    end
  end

  assign bus.busy   = (state != ST_IDLE);
  assign bus.done   = (state == ST_DONE);
  assign bus.result = res_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_sliced_logic_unit.sv
// tb/tb_sliced_logic_unit.sv - scoreboard bench for three sliced_logic_unit configurations
module tb_sliced_logic_unit;
  import logic_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n0, rst_n1;

  sliced_logic_unit_if #(.WIDTH(32)) if0 ();
  sliced_logic_unit_if #(.WIDTH(16)) if1 ();
  sliced_logic_unit_if #(.WIDTH(8))  if2 ();

  sliced_logic_unit #(.WIDTH(32), .SLICE(8)) dut0 (.clk(clk), .rst_n(rst_n0), .bus(if0));
  sliced_logic_unit #(.WIDTH(16), .SLICE(4)) dut1 (.clk(clk), .rst_n(rst_n1), .bus(if1));
  sliced_logic_unit #(.WIDTH(8),  .SLICE(8)) dut2 (.clk(clk), .rst_n(rst_n1), .bus(if2));

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          sc;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int bc0 = 0, bc1 = 0, bc2 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Latency is counted from the cycle start was presented to the cycle done is seen.
  task automatic mon(input int inst, input logic [31:0] res, input logic z, input int bc, input int n);
    exp_t e;
    bit   have = 0;
    if      (inst == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1; end
    else if (inst == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1; end
    else if (inst == 2 && q2.size() > 0) begin e = q2.pop_front(); have = 1; end
    if (!have) begin
      n_cmp++; n_bad++;
      $display("FAIL unexpected_done inst%0d: got done, required none", inst);
    end else begin
      check($sformatf("result inst%0d", inst), res, e.res);
      check($sformatf("zero inst%0d", inst), 32'(z), 32'(e.z));
      check($sformatf("latency inst%0d", inst), 32'(cyc - e.sc), 32'(n + 1));
      check($sformatf("busy_cycles inst%0d", inst), 32'(bc), 32'(n + 1));
    end
  endtask

  always @(negedge clk) begin
    if (if0.busy) bc0++;
    if (if1.busy) bc1++;
    if (if2.busy) bc2++;
    if (if0.done) mon(0, if0.result, if0.zero, bc0, 4);
    if (if1.done) mon(1, 32'(if1.result), if1.zero, bc1, 4);
    if (if2.done) mon(2, 32'(if2.result), if2.zero, bc2, 1);
    if (!if0.busy) bc0 = 0;
    if (!if1.busy) bc1 = 0;
    if (!if2.busy) bc2 = 0;
  end

  function automatic logic busy_of(input int inst);
    case (inst)
      0:       return if0.busy;
      1:       return if1.busy;
      default: return if2.busy;
    endcase
  endfunction

  task automatic set_start(input int inst, input logic s);
    case (inst)
      0:       if0.start = s;
      1:       if1.start = s;
      default: if2.start = s;
    endcase
  endtask

  task automatic drive(input int inst, input logic s, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    case (inst)
      0: begin if0.start = s; if0.op = op; if0.a = a; if0.b = b; end
      1: begin if1.start = s; if1.op = op; if1.a = a[15:0]; if1.b = b[15:0]; end
      default: begin if2.start = s; if2.op = op; if2.a = a[7:0]; if2.b = b[7:0]; end
    endcase
  endtask

  task automatic push_exp(input int inst, input logic [31:0] res, input logic z, input int sc);
    exp_t e;
    e.res = res; e.z = z; e.sc = sc;
    case (inst)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic wait_idle(input int inst);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy_of(inst)) return;
    end
    n_cmp++; n_bad++;
    $display("FAIL idle_timeout inst%0d: got busy, required idle within 40 cycles", inst);
  endtask

  task automatic issue(input int inst, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic z);
    wait_idle(inst);
    drive(inst, 1'b1, op, a, b);
    push_exp(inst, res, z, cyc);
    @(negedge clk);
    set_start(inst, 1'b0);
  endtask

  initial begin
    int sc;
    rst_n0 = 1'b0;
    rst_n1 = 1'b0;
    drive(0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(2, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    check("reset busy", 32'(if0.busy), 32'h0);
    check("reset done", 32'(if0.done), 32'h0);
    check("reset result", if0.result, 32'h0);
    check("reset zero", 32'(if0.zero), 32'h0);
    repeat (3) @(negedge clk);
    rst_n0 = 1'b1;
    rst_n1 = 1'b1;

    issue(0, OP_NOR, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    issue(0, OP_NOR, 32'h05453FAF, 32'h00000001, 32'hFABAC050, 1'b0);

    // Operands change and extra start pulses arrive while the XOR is running.
    wait_idle(0);
    drive(0, 1'b1, OP_XOR, 32'h00000000, 32'hFFFFFFFF);
    push_exp(0, 32'hFFFFFFFF, 1'b0, cyc);
    @(negedge clk); if0.start = 1'b0; if0.a = 32'hFFFFFFFF;
    @(negedge clk); if0.start = 1'b1;
    @(negedge clk); if0.start = 1'b0;
    @(negedge clk); if0.start = 1'b1;
    @(negedge clk); if0.start = 1'b0;
    wait_idle(0);
    repeat (3) @(negedge clk);
    check("hold result idle", if0.result, 32'hFFFFFFFF);

    issue(0, OP_AND,   32'h12345678, 32'h0F0F0F0F, 32'h02040608, 1'b0);
    issue(0, OP_OR,    32'h12340000, 32'h00005678, 32'h12345678, 1'b0);
    issue(0, OP_NAND,  32'hFFFF0000, 32'hFF00FF00, 32'h00FFFFFF, 1'b0);
    issue(0, OP_XNOR,  32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000000, 1'b1);
    issue(0, OP_PASSA, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 1'b0);
    issue(0, OP_ANDN,  32'hFFFFFFFF, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0);

    // Start held high: second request is taken on the first IDLE cycle after DONE.
    wait_idle(0);
    sc = cyc;
    drive(0, 1'b1, OP_XOR, 32'h0F0F0F0F, 32'h00FF00FF);
    push_exp(0, 32'h0FF00FF0, 1'b0, sc);
    @(negedge clk);
    drive(0, 1'b1, OP_OR, 32'h80000001, 32'h00000000);
    push_exp(0, 32'h80000001, 1'b0, sc + 6);
    repeat (6) @(negedge clk);
    set_start(0, 1'b0);

    // Reset lands after the second RUN edge; the aborted op gets no scoreboard entry.
    wait_idle(0);
    drive(0, 1'b1, OP_AND, 32'hFFFFFFFF, 32'h0000FFFF);
    @(negedge clk); set_start(0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n0 = 1'b0;
    #1;
    check("abort busy", 32'(if0.busy), 32'h0);
    check("abort done", 32'(if0.done), 32'h0);
    check("abort result", if0.result, 32'h0);
    check("abort zero", 32'(if0.zero), 32'h0);
    repeat (2) @(negedge clk);
    check("abort no done", 32'(if0.done), 32'h0);
    rst_n0 = 1'b1;
    issue(0, OP_AND, 32'hFFFFFFFF, 32'h0000FFFF, 32'h0000FFFF, 1'b0);

    issue(1, OP_ANDN, 32'h0000F0F0, 32'h0000FF00, 32'h000000F0, 1'b0);
    issue(1, OP_XNOR, 32'h00001234, 32'h00001234, 32'h0000FFFF, 1'b0);
    issue(2, OP_PASSA, 32'h00000000, 32'h000000FF, 32'h00000000, 1'b1);
    issue(2, OP_XOR,   32'h0000003C, 32'h0000000F, 32'h00000033, 1'b0);

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
    end
    repeat (4) @(negedge clk);
    check("pending inst0", 32'(q0.size()), 32'h0);
    check("pending inst1", 32'(q1.size()), 32'h0);
    check("pending inst2", 32'(q2.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sliced_logic_unit.md
SLICED_LOGIC_UNIT -- requirements
Module: sliced_logic_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter SLICE, default 8, bits processed per cycle; WIDTH SHALL be an integer multiple of SLICE, with N = WIDTH/SLICE.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request; accepted only when state is IDLE.
REQ-006 op  input  3  operation select, sampled at acceptance.
REQ-007 a  input  WIDTH  operand A, sampled at acceptance.
REQ-008 b  input  WIDTH  operand B, sampled at acceptance.
REQ-009 busy  output  1  high in RUN and DONE states.
REQ-010 done  output  1  one-cycle pulse marking result valid.
REQ-011 result  output  WIDTH  registered result.
REQ-012 zero  output  1  high when result == 0; valid from done, held until next acceptance.

Function
REQ-013 op encoding: 000 AND, 001 OR, 010 NOR, 011 XOR, 100 NAND, 101 XNOR, 110 A AND NOT B, 111 pass A.
REQ-014 FSM states: IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE after N RUN edges; DONE->IDLE unconditionally after one cycle.
REQ-015 Acceptance edge: latch a, b, op; clear slice counter to 0; clear result to 0.
REQ-016 Each RUN edge k (k = 0..N-1) SHALL write result[k*SLICE +: SLICE] from the same slice of the latched operands; order is LSB slice first.
REQ-017 Latency: done SHALL be high for exactly the cycle following the N-th RUN edge, i.e. N+1 cycles after the acceptance edge; minimum start-to-start period is N+2 cycles.
REQ-018 zero SHALL be registered on the final RUN edge from the completed result.
REQ-019 start in RUN or DONE SHALL be ignored, with no latching and no effect on the operation in progress.
REQ-020 start held high continuously SHALL be accepted again on the first IDLE cycle after DONE.
REQ-021 Changes on a, b or op after acceptance SHALL NOT affect the result.
REQ-022 result and zero SHALL hold their values in IDLE until the next acceptance.
REQ-023 Slice counter width SHALL be clog2(N), minimum 1 bit; when N=1, RUN lasts exactly one edge.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, busy=0, done=0, result=0, zero=0, counter=0, and latched operands=0, regardless of clk.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be processed normally.

Structure
REQ-026 Op-code constants and FSM state encodings SHALL reside in shared package logic_unit_pkg.
REQ-027 Combinational per-slice operator SHALL be sub-module logic_slice (parameter SLICE; inputs a, b, op; output y), instantiated once and fed by a counter-indexed mux.

Verification
REQ-028 Default params, op=NOR, a=FFFFFFFF, b=FFFFFFFF, start pulse -> done 5 cycles after acceptance edge, result=00000000, zero=1.
REQ-029 op=NOR, a=05453FAF, b=00000001 -> result=FABAC050, zero=0; busy high for exactly 5 cycles.
REQ-030 op=XOR, a=00000000, b=FFFFFFFF; at the next cycle, change a to FFFFFFFF and pulse start twice during RUN -> result=FFFFFFFF, only one done pulse.
REQ-031 Reset: drop rst_n after RUN edge 2 of an AND with a=FFFFFFFF, b=0000FFFF -> outputs 0 at once, no done; then a new AND with the same operands -> result=0000FFFF.
REQ-032 WIDTH=16, SLICE=4, op=AND NOT B (110), a=F0F0, b=FF00 -> result=00F0, done 5 cycles after acceptance.
REQ-033 WIDTH=8, SLICE=8 (N=1), op=pass A, a=00 -> result=00, zero=1, done 2 cycles after acceptance.
